// File: rtl/gcd_pkg.sv
// Shared definitions for the streaming binary-GCD engine: FSM states and
// default operand/tag widths.
package gcd_pkg;

  localparam int GCD_WIDTH_DEF = 16;
  localparam int GCD_TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_e;

  // Width of the per-result CALC-cycle counter for a given operand width.
  function automatic int gcd_iter_w(input int width);
    return $clog2(2 * width + 2);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational step of Stein's binary GCD.
// The caller iterates this step until done is set.
module gcd_step #(
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [KW-1:0]    K_ONE = KW'(1);

  logic [WIDTH-1:0] diff_ab_s;
  logic [WIDTH-1:0] diff_ba_s;

  assign diff_ab_s = a - b;
  assign diff_ba_s = b - a;

  // Select the first matching Stein rule. Because k counts only common
  // factors of two, (a|b)<<k cannot overflow WIDTH bits.
  always_comb begin
    a_nxt  = a;
    b_nxt  = b;
    k_nxt  = k;
    done   = 1'b0;
    result = ZERO;
    if ((a == ZERO) || (b == ZERO)) begin
      done   = 1'b1;
      result = (a | b) << k;
    end else if (!a[0] && !b[0]) begin
      a_nxt = a >> 1;
      b_nxt = b >> 1;
      k_nxt = k + K_ONE;
    end else if (!a[0]) begin
      a_nxt = a >> 1;
    end else if (!b[0]) begin
      b_nxt = b >> 1;
    end else if (a >= b) begin
      a_nxt = {1'b0, diff_ab_s[WIDTH-1:1]};
    end else begin
      b_nxt = {1'b0, diff_ba_s[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/gcd_stream.sv
// Streaming GCD engine: accepts {a,b}+tag, runs one Stein step per cycle and
// presents gcd, tag and step count through a valid/ready output.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF,
  parameter int TAG_W = GCD_TAG_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [2*WIDTH-1:0]               in_data,
  input  logic [TAG_W-1:0]                 in_tag,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [$clog2(2*WIDTH+2)-1:0]     out_iters,
  input  logic                             out_ready
);

  localparam int KW     = $clog2(WIDTH + 1);
  localparam int ITER_W = gcd_iter_w(WIDTH);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  gcd_state_e          state_r;
  gcd_state_e          state_nxt_s;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [KW-1:0]       k_r;
  logic [TAG_W-1:0]    tag_r;
  logic [ITER_W-1:0]   iters_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [TAG_W-1:0]    out_tag_r;
  logic [ITER_W-1:0]   out_iters_r;
  logic                ready_s;
  logic                accept_s;
  logic [WIDTH-1:0]    a_nxt_s;
  logic [WIDTH-1:0]    b_nxt_s;
  logic [KW-1:0]       k_nxt_s;
  logic                done_s;
  logic [WIDTH-1:0]    result_s;
  logic [ITER_W-1:0]   iters_inc_s;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .a      (a_r),
    .b      (b_r),
    .k      (k_r),
    .a_nxt  (a_nxt_s),
    .b_nxt  (b_nxt_s),
    .k_nxt  (k_nxt_s),
    .done   (done_s),
    .result (result_s)
  );

  assign iters_inc_s = iters_r + ITER_ONE;
  // Reset is folded in so the engine never advertises readiness while held.
  assign accept_s    = in_valid && ready_s && !reset;
  assign in_ready    = ready_s && !reset;
  assign out_valid   = (state_r == ST_DONE);
  assign out_data    = out_data_r;
  assign out_tag     = out_tag_r;
  assign out_iters   = out_iters_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and input-ready decode; DONE frees the input on the handshake cycle.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        if (in_valid) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ready_s = 1'b1;
          if (in_valid) begin
            state_nxt_s = ST_CALC;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand, step-count and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      k_r         <= {KW{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      iters_r     <= {ITER_W{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      out_iters_r <= {ITER_W{1'b0}};
    end else if (accept_s) begin
      a_r     <= in_data[2*WIDTH-1:WIDTH];
      b_r     <= in_data[WIDTH-1:0];
      k_r     <= {KW{1'b0}};
      tag_r   <= in_tag;
      iters_r <= {ITER_W{1'b0}};
    end else if (state_r == ST_CALC) begin
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      k_r     <= k_nxt_s;
      iters_r <= iters_inc_s;
      // The terminating step counts toward the reported iterations.
      if (done_s) begin
        out_data_r  <= result_s;
        out_tag_r   <= tag_r;
        out_iters_r <= iters_inc_s;
      end else begin
        out_data_r  <= out_data_r;
        out_tag_r   <= out_tag_r;
        out_iters_r <= out_iters_r;
      end
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      k_r     <= k_r;
      iters_r <= iters_r;
    end
  end

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and randomized self-checking bench for gcd_stream at WIDTH 16, 8 and 32.
module tb_gcd_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        v   [3];
  logic        rdy [3];
  logic [63:0] a_d;
  logic [63:0] b_d;
  logic [3:0]  tg;

  logic ir0, ov0; logic [15:0] od0; logic [3:0] ot0; logic [5:0] oi0;
  logic ir1, ov1; logic [7:0]  od1; logic [3:0] ot1; logic [4:0] oi1;
  logic ir2, ov2; logic [31:0] od2; logic [3:0] ot2; logic [6:0] oi2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gcd_stream #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_data({a_d[15:0], b_d[15:0]}),
    .in_tag(tg), .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_tag(ot0),
    .out_iters(oi0), .out_ready(rdy[0]));

  gcd_stream #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_data({a_d[7:0], b_d[7:0]}),
    .in_tag(tg), .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_tag(ot1),
    .out_iters(oi1), .out_ready(rdy[1]));

  gcd_stream #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_data({a_d[31:0], b_d[31:0]}),
    .in_tag(tg), .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_tag(ot2),
    .out_iters(oi2), .out_ready(rdy[2]));

  function automatic logic [63:0] ref_gcd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 64'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic smp(input int s, output logic ov, output logic ir, output logic [63:0] od,
                     output logic [3:0] ot, output logic [63:0] oi);
    case (s)
      0: begin ov = ov0; ir = ir0; od = {48'd0, od0}; ot = ot0; oi = {58'd0, oi0}; end
      1: begin ov = ov1; ir = ir1; od = {56'd0, od1}; ot = ot1; oi = {59'd0, oi1}; end
      default: begin ov = ov2; ir = ir2; od = {32'd0, od2}; ot = ot2; oi = {57'd0, oi2}; end
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; offers one request, returns at the negedge after the accept edge.
  task automatic send(input int s, input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    a_d  = a;
    b_d  = b;
    tg   = t;
    v[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v[s] = 1'b0;
  endtask

  task automatic wait_valid(input int s, input int budget, output int cyc);
    logic ov, ir; logic [63:0] od; logic [3:0] ot; logic [63:0] oi;
    cyc = 0;
    smp(s, ov, ir, od, ot, oi);
    while (!ov && cyc < budget) begin
      @(negedge clk);
      cyc++;
      smp(s, ov, ir, od, ot, oi);
    end
    check("valid_timeout", {63'd0, ov}, 64'd1);
  endtask

  task automatic run_random(input int s, input int w, input int n);
    logic [63:0] mask, a, b, e, od, oi;
    logic ov, ir;
    logic [3:0] ot;
    int cyc, first;
    bit done;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom} & mask;
      b = {$urandom, $urandom} & mask;
      if (i % 16 == 3) a = 64'd0;
      if (i % 16 == 7) b = 64'd0;
      if (i % 16 == 9) b = a << 1;
      b = b & mask;
      e = ref_gcd(a, b);
      rdy[s] = 1'b0;
      send(s, a, b, i[3:0]);
      done  = 1'b0;
      first = -1;
      cyc   = 0;
      while (!done && cyc < 4 * w + 60) begin
        smp(s, ov, ir, od, ot, oi);
        if (ov) begin
          check("rnd_data", od, e);
          check("rnd_tag", {60'd0, ot}, {60'd0, i[3:0]});
          if (first < 0) begin
            first = cyc;
            check("rnd_latency_ok", {63'd0, (first <= 2 * w + 2)}, 64'd1);
          end
        end
        rdy[s] = 1'($urandom_range(0, 1));
        if (ov && rdy[s]) begin
          @(negedge clk);
          smp(s, ov, ir, od, ot, oi);
          check("rnd_no_dup", {63'd0, ov}, 64'd0);
          done = 1'b1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
      check("rnd_delivered", {63'd0, done}, 64'd1);
    end
    rdy[s] = 1'b0;
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i]   = 1'b0;
      rdy[i] = 1'b0;
    end
    a_d = 64'd0;
    b_d = 64'd0;
    tg  = 4'd0;

    // Reset held: no readiness, no output.
    @(negedge clk);
    check("rst_in_ready", {63'd0, ir0}, 64'd0);
    check("rst_out_valid", {63'd0, ov0}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_in_ready", {63'd0, ir0}, 64'd1);
    check("idle_out_valid", {63'd0, ov0}, 64'd0);
    check("idle_out_data", {48'd0, od0}, 64'd0);
    check("idle_out_tag", {60'd0, ot0}, 64'd0);
    check("idle_out_iters", {58'd0, oi0}, 64'd0);
    @(negedge clk);

    // gcd(48,32) = 16 in 8 steps.
    rdy[0] = 1'b1;
    send(0, 64'h30, 64'h20, 4'd3);
    wait_valid(0, 40, cyc);
    check("g48_32_data", {48'd0, od0}, 64'd16);
    check("g48_32_tag", {60'd0, ot0}, 64'd3);
    check("g48_32_iters", {58'd0, oi0}, 64'd8);
    check("g48_32_latency", 64'(cyc), 64'd8);
    @(negedge clk);
    check("g48_32_consumed", {63'd0, ov0}, 64'd0);
    check("g48_32_back_idle", {63'd0, ir0}, 64'd1);

    // Zero operands.
    send(0, 64'h0, 64'h7, 4'd5);
    wait_valid(0, 40, cyc);
    check("g0_7_data", {48'd0, od0}, 64'd7);
    check("g0_7_iters", {58'd0, oi0}, 64'd1);
    check("g0_7_tag", {60'd0, ot0}, 64'd5);
    @(negedge clk);
    send(0, 64'h7, 64'h0, 4'd6);
    wait_valid(0, 40, cyc);
    check("g7_0_data", {48'd0, od0}, 64'd7);
    check("g7_0_iters", {58'd0, oi0}, 64'd1);
    @(negedge clk);
    send(0, 64'h0, 64'h0, 4'd7);
    wait_valid(0, 40, cyc);
    check("g0_0_valid", {63'd0, ov0}, 64'd1);
    check("g0_0_data", {48'd0, od0}, 64'd0);
    check("g0_0_iters", {58'd0, oi0}, 64'd1);
    @(negedge clk);

    // Worst-ish case: gcd(0xFFFF,1) = 1 in 17 steps.
    send(0, 64'hFFFF, 64'h1, 4'd8);
    wait_valid(0, 60, cyc);
    check("gffff_1_data", {48'd0, od0}, 64'd1);
    check("gffff_1_iters", {58'd0, oi0}, 64'd17);
    check("gffff_1_latency", 64'(cyc), 64'd17);
    @(negedge clk);

    // Backpressure: gcd(21,35)=7 in 4 steps, held for 5 stalled cycles.
    rdy[0] = 1'b0;
    send(0, 64'h15, 64'h23, 4'd9);
    check("calc_in_ready", {63'd0, ir0}, 64'd0);
    wait_valid(0, 40, cyc);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", {48'd0, od0}, 64'd7);
      check("bp_tag", {60'd0, ot0}, 64'd9);
      check("bp_iters", {58'd0, oi0}, 64'd4);
      check("bp_valid", {63'd0, ov0}, 64'd1);
      check("bp_in_ready", {63'd0, ir0}, 64'd0);
      @(negedge clk);
    end
    rdy[0] = 1'b1;
    a_d = 64'hC;
    b_d = 64'h8;
    tg  = 4'd10;
    v[0] = 1'b1;
    #1;
    check("bp_release_ready", {63'd0, ir0}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    v[0] = 1'b0;
    #1;
    check("b2b_in_calc_valid", {63'd0, ov0}, 64'd0);
    check("b2b_in_calc_ready", {63'd0, ir0}, 64'd0);
    wait_valid(0, 40, cyc);
    check("g12_8_data", {48'd0, od0}, 64'd4);
    check("g12_8_tag", {60'd0, ot0}, 64'd10);
    check("g12_8_iters", {58'd0, oi0}, 64'd6);
    @(negedge clk);

    // Reset mid-CALC discards the request.
    send(0, 64'h30, 64'h20, 4'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, ov0}, 64'd0);
    check("midrst_in_ready", {63'd0, ir0}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_after_ready", {63'd0, ir0}, 64'd1);
    check("midrst_after_valid", {63'd0, ov0}, 64'd0);
    @(negedge clk);
    send(0, 64'h15, 64'h23, 4'd2);
    wait_valid(0, 40, cyc);
    check("post_rst_data", {48'd0, od0}, 64'd7);
    check("post_rst_tag", {60'd0, ot0}, 64'd2);
    @(negedge clk);

    // Randomized runs against a Euclid reference.
    run_random(1, 8, 200);
    run_random(2, 32, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
